// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - decode, forwarding and ALU-side signal bundle for ex_operand_stage
interface ex_operand_stage_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] pc_i;
    logic [4:0]      rs1_addr_i;
    logic [4:0]      rs2_addr_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [XLEN-1:0] imm_i;
    logic            op1_pc_i;
    logic            op2_imm_i;
    logic            shamt_i;
    logic [7:0]      opcode_i;
    logic            alu_op_i;
    logic [4:0]      rd_addr_i;
    logic            ex_we_i;
    logic [4:0]      ex_rd_i;
    logic [XLEN-1:0] ex_data_i;
    logic            wb_we_i;
    logic [4:0]      wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] op1_o;
    logic [XLEN-1:0] op2_o;
    logic [7:0]      opcode_o;
    logic            alu_op_o;
    logic [4:0]      rd_addr_o;

    modport slave (
        input  flush_i, valid_i, pc_i, rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i,
        input  imm_i, op1_pc_i, op2_imm_i, shamt_i, opcode_i, alu_op_i, rd_addr_i,
        input  ex_we_i, ex_rd_i, ex_data_i, wb_we_i, wb_rd_i, wb_data_i, ready_i,
        output ready_o, valid_o, op1_o, op2_o, opcode_o, alu_op_o, rd_addr_o
    );

    modport master (
        output flush_i, valid_i, pc_i, rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i,
        output imm_i, op1_pc_i, op2_imm_i, shamt_i, opcode_i, alu_op_i, rd_addr_i,
        output ex_we_i, ex_rd_i, ex_data_i, wb_we_i, wb_rd_i, wb_data_i, ready_i,
        input  ready_o, valid_o, op1_o, op2_o, opcode_o, alu_op_o, rd_addr_o
    );
endinterface

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - operand forwarding/select stage with two-entry skid buffer ahead of the ALU
module ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    ex_operand_stage_if.slave  bus
);
    typedef enum logic [1:0] {S_EMPTY, S_FULL1, S_FULL2} state_t;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [7:0]      opcode;
        logic            alu_op;
        logic [4:0]      rd_addr;
    } entry_t;

    state_t          state_q, state_d;
    entry_t          main_q, skid_q, in_entry;
    logic            valid_q, ready_q;
    logic            in_xfer, out_xfer;
    logic            load_main_in, load_main_skid, load_skid;
    logic [XLEN-1:0] rs1_res, rs2_res, op2_sel;

    // EX beats WB; register 0 never forwards and always reads as zero
    always_comb begin
        rs1_res = bus.rs1_data_i;
        if (bus.rs1_addr_i == 5'd0)
            rs1_res = '0;
        else if (bus.ex_we_i && bus.ex_rd_i == bus.rs1_addr_i)
            rs1_res = bus.ex_data_i;
        else if (bus.wb_we_i && bus.wb_rd_i == bus.rs1_addr_i)
            rs1_res = bus.wb_data_i;

        rs2_res = bus.rs2_data_i;
        if (bus.rs2_addr_i == 5'd0)
            rs2_res = '0;
        else if (bus.ex_we_i && bus.ex_rd_i == bus.rs2_addr_i)
            rs2_res = bus.ex_data_i;
        else if (bus.wb_we_i && bus.wb_rd_i == bus.rs2_addr_i)
            rs2_res = bus.wb_data_i;
    end

    always_comb begin
        op2_sel          = bus.op2_imm_i ? bus.imm_i : rs2_res;
        in_entry         = '0;
        in_entry.op1     = bus.op1_pc_i ? bus.pc_i : rs1_res;
        in_entry.op2     = bus.shamt_i ? {{(XLEN-5){1'b0}}, op2_sel[4:0]} : op2_sel;
        in_entry.opcode  = bus.opcode_i;
        in_entry.alu_op  = bus.alu_op_i;
        in_entry.rd_addr = bus.rd_addr_i;
    end

    assign in_xfer  = bus.valid_i && ready_q;
    assign out_xfer = valid_q && bus.ready_i;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_xfer) begin
                        state_d      = S_FULL1;
                        load_main_in = 1'b1;
                    end
                end
                S_FULL1: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = S_FULL2;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL2: begin
                    if (out_xfer) begin
                        state_d        = S_FULL1;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // valid/ready are flopped from the next state so neither output has a path from ready_i
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != S_EMPTY);
            ready_q <= (state_d != S_FULL2);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)
                main_q <= in_entry;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= in_entry;
        end
    end

    assign bus.valid_o   = valid_q;
    assign bus.ready_o   = ready_q;
    assign bus.op1_o     = main_q.op1;
    assign bus.op2_o     = main_q.op2;
    assign bus.opcode_o  = main_q.opcode;
    assign bus.alu_op_o  = main_q.alu_op;
    assign bus.rd_addr_o = main_q.rd_addr;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed and random checks of ex_operand_stage against a FIFO reference model
module tb_ex_operand_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ex_operand_stage_if #(.XLEN(32)) bus ();

    ex_operand_stage #(.XLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [7:0]  opcode;
        logic        alu_op;
        logic [4:0]  rd;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'h0;
        if (bus.ex_we_i && bus.ex_rd_i == a) return bus.ex_data_i;
        if (bus.wb_we_i && bus.wb_rd_i == a) return bus.wb_data_i;
        return rf;
    endfunction

    function automatic ent_t model_entry();
        ent_t e;
        e.op1    = bus.op1_pc_i ? bus.pc_i : resolve(bus.rs1_addr_i, bus.rs1_data_i);
        e.op2    = bus.op2_imm_i ? bus.imm_i : resolve(bus.rs2_addr_i, bus.rs2_data_i);
        if (bus.shamt_i) e.op2 = e.op2 % 32;
        e.opcode = bus.opcode_i;
        e.alu_op = bus.alu_op_i;
        e.rd     = bus.rd_addr_i;
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, {31'b0, bus.valid_o}, {31'b0, q.size() > 0});
        chk({tag, ".ready"}, {31'b0, bus.ready_o}, {31'b0, q.size() < 2});
        if (q.size() > 0) begin
            chk({tag, ".op1"}, bus.op1_o, q[0].op1);
            chk({tag, ".op2"}, bus.op2_o, q[0].op2);
            chk({tag, ".opcode"}, {24'b0, bus.opcode_o}, {24'b0, q[0].opcode});
            chk({tag, ".alu_op"}, {31'b0, bus.alu_op_o}, {31'b0, q[0].alu_op});
            chk({tag, ".rd"}, {27'b0, bus.rd_addr_o}, {27'b0, q[0].rd});
        end
    endtask

    // Inputs are set just after a negedge; this advances one clock and re-checks at the next negedge
    task automatic tick(input string tag);
        ent_t e;
        logic acc, pop;
        acc = bus.valid_i && (q.size() < 2);
        pop = (q.size() > 0) && bus.ready_i;
        e   = model_entry();
        @(posedge clk);
        if (bus.flush_i) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        bus.flush_i = 0; bus.valid_i = 0; bus.pc_i = 0;
        bus.rs1_addr_i = 0; bus.rs2_addr_i = 0; bus.rs1_data_i = 0; bus.rs2_data_i = 0;
        bus.imm_i = 0; bus.op1_pc_i = 0; bus.op2_imm_i = 0; bus.shamt_i = 0;
        bus.opcode_i = 0; bus.alu_op_i = 0; bus.rd_addr_i = 0;
        bus.ex_we_i = 0; bus.ex_rd_i = 0; bus.ex_data_i = 0;
        bus.wb_we_i = 0; bus.wb_rd_i = 0; bus.wb_data_i = 0;
        bus.ready_i = 1;
    endtask

    task automatic set_instr(input logic [7:0] opc, input logic [4:0] rd);
        bus.valid_i = 1; bus.opcode_i = opc; bus.rd_addr_i = rd;
        bus.alu_op_i = opc[0]; bus.pc_i = {24'h0, opc};
        bus.op1_pc_i = 1;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, ".valid"}, {31'b0, bus.valid_o}, 32'h0);
        chk({tag, ".ready"}, {31'b0, bus.ready_o}, 32'h1);
        chk({tag, ".op1"}, bus.op1_o, 32'h0);
        chk({tag, ".op2"}, bus.op2_o, 32'h0);
        chk({tag, ".opcode"}, {24'b0, bus.opcode_o}, 32'h0);
        chk({tag, ".alu_op"}, {31'b0, bus.alu_op_o}, 32'h0);
        chk({tag, ".rd"}, {27'b0, bus.rd_addr_o}, 32'h0);
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        reset_check("reset");
        rst_n = 1;
        @(negedge clk);
        check_outputs("post_reset");

        // EX wins over WB, then WB alone
        bus.valid_i = 1; bus.rs1_addr_i = 5; bus.rs1_data_i = 32'h11;
        bus.ex_we_i = 1; bus.ex_rd_i = 5; bus.ex_data_i = 32'h22;
        bus.wb_we_i = 1; bus.wb_rd_i = 5; bus.wb_data_i = 32'h33;
        tick("fwd_ex");
        chk("fwd_ex_const", bus.op1_o, 32'h22);
        bus.ex_we_i = 0;
        tick("fwd_wb");
        chk("fwd_wb_const", bus.op1_o, 32'h33);

        bus.rs2_addr_i = 0; bus.rs2_data_i = 32'h5;
        bus.ex_we_i = 1; bus.ex_rd_i = 0; bus.ex_data_i = 32'hFFFF_FFFF;
        tick("x0");
        chk("x0_const", bus.op2_o, 32'h0);

        bus.op1_pc_i = 1; bus.pc_i = 32'h100;
        bus.op2_imm_i = 1; bus.shamt_i = 1; bus.imm_i = 32'h0000_0423;
        tick("select");
        chk("sel_pc_const", bus.op1_o, 32'h100);
        chk("sel_shamt_const", bus.op2_o, 32'h3);
        idle_inputs();
        tick("drain");

        // backpressure: A, B, C with ready_i low
        bus.ready_i = 0;
        set_instr(8'hA1, 5'd1); tick("bp_a");
        set_instr(8'hB2, 5'd2); tick("bp_b");
        chk("bp_ready_low", {31'b0, bus.ready_o}, 32'h0);
        set_instr(8'hC3, 5'd3); tick("bp_c_held");
        chk("bp_head_a", {24'b0, bus.opcode_o}, 32'hA1);
        bus.ready_i = 1;
        tick("bp_rel1");
        chk("bp_head_b", {24'b0, bus.opcode_o}, 32'hB2);
        tick("bp_rel2");
        bus.valid_i = 0;
        chk("bp_head_c", {24'b0, bus.opcode_o}, 32'hC3);
        tick("bp_rel3");
        chk("bp_empty", {31'b0, bus.valid_o}, 32'h0);

        // flush in FULL2 with a simultaneous valid input
        bus.ready_i = 0;
        set_instr(8'h10, 5'd4); tick("fl_a");
        set_instr(8'h11, 5'd5); tick("fl_b");
        set_instr(8'h12, 5'd6); bus.flush_i = 1; tick("fl_flush");
        chk("fl_valid", {31'b0, bus.valid_o}, 32'h0);
        chk("fl_ready", {31'b0, bus.ready_o}, 32'h1);
        idle_inputs();
        repeat (3) tick("fl_after");

        // async reset while FULL2
        bus.ready_i = 0;
        set_instr(8'h20, 5'd7); tick("rs_a");
        set_instr(8'h21, 5'd8); tick("rs_b");
        #2 rst_n = 0;
        #1 reset_check("async_reset");
        q.delete();
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_outputs("after_reset");

        // random traffic with forwarding on a small register range
        for (int i = 0; i < 400; i++) begin
            bus.valid_i    = $urandom_range(0, 3) != 0;
            bus.ready_i    = $urandom_range(0, 2) != 0;
            bus.flush_i    = $urandom_range(0, 19) == 0;
            bus.pc_i       = $urandom;
            bus.rs1_addr_i = 5'($urandom_range(0, 3));
            bus.rs2_addr_i = 5'($urandom_range(0, 3));
            bus.rs1_data_i = $urandom;
            bus.rs2_data_i = $urandom;
            bus.imm_i      = $urandom;
            bus.op1_pc_i   = $urandom_range(0, 3) == 0;
            bus.op2_imm_i  = $urandom_range(0, 3) == 0;
            bus.shamt_i    = $urandom_range(0, 3) == 0;
            bus.opcode_i   = 8'($urandom);
            bus.alu_op_i   = 1'($urandom);
            bus.rd_addr_i  = 5'($urandom);
            bus.ex_we_i    = 1'($urandom);
            bus.ex_rd_i    = 5'($urandom_range(0, 3));
            bus.ex_data_i  = $urandom;
            bus.wb_we_i    = 1'($urandom);
            bus.wb_rd_i    = 5'($urandom_range(0, 3));
            bus.wb_data_i  = $urandom;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
